// File: rtl/sipo_pkg.sv
// Shared helpers for the serial-in/parallel-out frame loader.
// Frame geometry (chunks per frame, counter width) and chunk-order encodings
// live here so the top level and the shift core agree on them.
package sipo_pkg;

    // Chunk order: first chunk lands in the top slice (MSB first) or the
    // bottom slice (LSB first) of the assembled frame.
    localparam int unsigned ORDER_MSB_FIRST = 0;
    localparam int unsigned ORDER_LSB_FIRST = 1;

    // Number of N-bit chunks in an M-bit frame.
    function automatic int unsigned chunks(input int unsigned m, input int unsigned n);
        return m / n;
    endfunction

    // Width of a counter holding 0..k-1, never narrower than one bit.
    function automatic int unsigned cnt_w(input int unsigned k);
        return (k <= 2) ? 1 : $clog2(k);
    endfunction

endpackage

// File: rtl/sipo_shift_core.sv
// Shift register that assembles a frame one chunk at a time.
// next_value_o is the frame as it would look after shifting din_i in; the
// top level uses it to load the shadow register on the completing chunk
// without waiting a cycle for the shift register to catch up.
module sipo_shift_core
    import sipo_pkg::*;
#(
    parameter int unsigned N         = 4,
    parameter int unsigned M         = 64,
    parameter int unsigned LSB_FIRST = ORDER_MSB_FIRST
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         shift_en_i,
    input  logic         clear_i,
    input  logic [N-1:0] din_i,
    output logic [M-1:0] next_value_o,
    output logic [M-1:0] value_o
);

    logic [M-1:0] value_q;
    logic [M-1:0] value_d;

    if (N < 1 || (M % N) != 0 || (M / N) < 2) begin : g_bad_params
        $error("sipo_shift_core: M must be a multiple of N with M/N >= 2");
    end

    // Chunk order decides which end the new chunk enters from.
    if (LSB_FIRST == ORDER_LSB_FIRST) begin : g_lsb_first
        assign next_value_o = {din_i, value_q[M-1:N]};
    end else begin : g_msb_first
        assign next_value_o = {value_q[M-N-1:0], din_i};
    end

    // Clear wins over shift: a completed or aborted frame restarts from zero.
    always_comb begin
        value_d = value_q;
        if (clear_i) begin
            value_d = '0;
        end else if (shift_en_i) begin
            value_d = next_value_o;
        end
    end

    // Shift register state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            value_q <= '0;
        end else begin
            value_q <= value_d;
        end
    end

    assign value_o = value_q;

endmodule

// File: rtl/sipo_frame_loader.sv
// Double-buffered serial-in/parallel-out frame loader.
// Chunks shift into a working register; the completing chunk copies the whole
// frame into a shadow register that drives out_data, so a finished frame stays
// stable while the next one assembles. Only the completing chunk can stall on
// an unconsumed frame; earlier chunks of the next frame are always taken.
module sipo_frame_loader
    import sipo_pkg::*;
#(
    parameter int unsigned N         = 4,
    parameter int unsigned M         = 64,
    parameter int unsigned LSB_FIRST = ORDER_MSB_FIRST,
    localparam int unsigned K        = chunks(M, N),
    localparam int unsigned CW       = cnt_w(K)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          ce,
    input  logic          in_valid,
    input  logic [N-1:0]  in_data,
    output logic          in_ready,
    input  logic          frame_clear,
    output logic          out_valid,
    output logic [M-1:0]  out_data,
    input  logic          out_ready,
    output logic [CW-1:0] chunk_count
);

    localparam logic [CW-1:0] LAST_IDX = CW'(K - 1);

    if (N < 1 || (M % N) != 0 || (M / N) < 2) begin : g_bad_params
        $error("sipo_frame_loader: M must be a multiple of N with M/N >= 2");
    end

    logic [CW-1:0] cnt_q,       cnt_d;
    logic          out_valid_q, out_valid_d;
    logic [M-1:0]  out_data_q,  out_data_d;

    logic          is_last;
    logic          acc;
    logic          complete;
    logic          shift_en;
    logic          core_clear;
    logic [M-1:0]  frame_next;
    logic [M-1:0]  frame_partial;

    assign is_last  = (cnt_q == LAST_IDX);

    // The completing chunk may enter only if the shadow register is free or
    // is being emptied in this very cycle; everything else is gated by ce and
    // by an abort request.
    assign in_ready = ce & ~frame_clear & (~is_last | ~out_valid_q | out_ready);

    assign acc        = in_valid & in_ready;
    assign complete   = acc & is_last;
    assign shift_en   = acc & ~is_last;
    assign core_clear = frame_clear | complete;

    sipo_shift_core #(
        .N         (N),
        .M         (M),
        .LSB_FIRST (LSB_FIRST)
    ) u_core (
        .clk          (clk),
        .rst          (rst),
        .shift_en_i   (shift_en),
        .clear_i      (core_clear),
        .din_i        (in_data),
        .next_value_o (frame_next),
        .value_o      (frame_partial)
    );

    // Chunk counter: restarts on abort or completion, advances on accept.
    always_comb begin
        cnt_d = cnt_q;
        if (frame_clear || complete) begin
            cnt_d = '0;
        end else if (acc) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Output handshake: a completion in the same cycle as a take keeps
    // out_valid high, so back-to-back frames have no bubble.
    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        if (complete) begin
            out_valid_d = 1'b1;
            out_data_d  = frame_next;
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // Counter and shadow register state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            cnt_q       <= cnt_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end

    assign out_valid   = out_valid_q;
    assign out_data    = out_data_q;
    assign chunk_count = cnt_q;

    // The partial frame is internal; it is exposed only for hierarchical
    // debug visibility and deliberately unused here.
    logic unused_partial;
    assign unused_partial = ^frame_partial;

endmodule

// File: tb/tb_sipo_frame_loader.sv
// Bench for sipo_frame_loader, N=4, M=16 (K=4).
// Two instances share all inputs: u_msb (LSB_FIRST=0) and u_lsb (LSB_FIRST=1).
// Each frame's expected value for both orders is pushed when stimulus starts;
// a monitor pops and compares on every out_valid & out_ready handshake.
module tb_sipo_frame_loader;

    logic        clk = 1'b0;
    logic        rst;
    logic        ce;
    logic        in_valid;
    logic [3:0]  in_data;
    logic        frame_clear;
    logic        out_ready;

    logic        rdy0, rdy1;
    logic        ov0, ov1;
    logic [15:0] od0, od1;
    logic [1:0]  cnt0, cnt1;

    int errors = 0;
    int checks = 0;

    logic [15:0] q0[$];
    logic [15:0] q1[$];

    always #5 clk = ~clk;

    sipo_frame_loader #(.N(4), .M(16), .LSB_FIRST(0)) u_msb (
        .clk         (clk),
        .rst         (rst),
        .ce          (ce),
        .in_valid    (in_valid),
        .in_data     (in_data),
        .in_ready    (rdy0),
        .frame_clear (frame_clear),
        .out_valid   (ov0),
        .out_data    (od0),
        .out_ready   (out_ready),
        .chunk_count (cnt0)
    );

    sipo_frame_loader #(.N(4), .M(16), .LSB_FIRST(1)) u_lsb (
        .clk         (clk),
        .rst         (rst),
        .ce          (ce),
        .in_valid    (in_valid),
        .in_data     (in_data),
        .in_ready    (rdy1),
        .frame_clear (frame_clear),
        .out_valid   (ov1),
        .out_data    (od1),
        .out_ready   (out_ready),
        .chunk_count (cnt1)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Both orders of the same four chunks, first chunk c[0].
    task automatic push_frame(input logic [3:0] c0, input logic [3:0] c1,
                              input logic [3:0] c2, input logic [3:0] c3);
        q0.push_back({c0, c1, c2, c3});
        q1.push_back({c3, c2, c1, c0});
    endtask

    // Called at a falling edge; returns at the falling edge after acceptance.
    task automatic send(input logic [3:0] d);
        int n;
        n = 0;
        in_valid = 1'b1;
        in_data  = d;
        #1;
        while (!rdy0 && n < 50) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (!rdy0) begin
            errors++;
            checks++;
            $display("FAIL send_timeout: in_ready stuck low for chunk 0x%0h", d);
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // Scoreboard monitor: inputs settle at the falling edge, so a handshake
    // seen here completes at the next rising edge.
    always @(negedge clk) begin
        #2;
        if (!rst && out_ready) begin
            if (ov0) begin
                if (q0.size() == 0) begin
                    errors++; checks++;
                    $display("FAIL msb_unexpected_frame: got 0x%0h expected none", od0);
                end else begin
                    chk("msb_frame", {16'h0, od0}, {16'h0, q0.pop_front()});
                end
            end
            if (ov1) begin
                if (q1.size() == 0) begin
                    errors++; checks++;
                    $display("FAIL lsb_unexpected_frame: got 0x%0h expected none", od1);
                end else begin
                    chk("lsb_frame", {16'h0, od1}, {16'h0, q1.pop_front()});
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; ce = 1'b1; in_valid = 1'b0; in_data = 4'h0;
        frame_clear = 1'b0; out_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("reset_cnt", {30'h0, cnt0}, 32'h0);
        chk("reset_valid", {31'h0, ov0}, 32'h0);
        chk("reset_data", {16'h0, od0}, 32'h0);
        @(negedge clk);

        // Reset mid-frame with a pending frame and a partial frame.
        push_frame(4'h1, 4'h2, 4'h3, 4'h4);
        send(4'h1); send(4'h2); send(4'h3); send(4'h4);
        #1;
        chk("pending_before_rst", {31'h0, ov0}, 32'h1);
        @(negedge clk);
        send(4'h1); send(4'h2);
        #1;
        chk("cnt_before_rst", {30'h0, cnt0}, 32'h2);
        #2;
        rst = 1'b1;
        #1;
        chk("rst_async_cnt", {30'h0, cnt0}, 32'h0);
        chk("rst_async_valid", {31'h0, ov0}, 32'h0);
        chk("rst_async_data", {16'h0, od0}, 32'h0);
        chk("rst_async_data_lsb", {16'h0, od1}, 32'h0);
        q0.delete(); q1.delete();
        @(negedge clk);
        rst = 1'b0;
        out_ready = 1'b1;
        push_frame(4'h5, 4'h6, 4'h7, 4'h8);
        send(4'h5); send(4'h6); send(4'h7); send(4'h8);
        @(negedge clk);

        // Chunk order and single-cycle latency with out_ready held high.
        push_frame(4'hA, 4'hB, 4'hC, 4'hD);
        #1; chk("cnt_0", {30'h0, cnt0}, 32'h0);
        send(4'hA); #1; chk("cnt_1", {30'h0, cnt0}, 32'h1);
        send(4'hB); #1; chk("cnt_2", {30'h0, cnt0}, 32'h2);
        send(4'hC); #1; chk("cnt_3", {30'h0, cnt0}, 32'h3);
        send(4'hD); #1;
        chk("cnt_wrap", {30'h0, cnt0}, 32'h0);
        chk("latency_valid", {31'h0, ov0}, 32'h1);
        chk("msb_abcd", {16'h0, od0}, 32'hABCD);
        chk("lsb_dcba", {16'h0, od1}, 32'hDCBA);
        @(negedge clk); #1;
        chk("valid_one_cycle", {31'h0, ov0}, 32'h0);
        @(negedge clk);

        // Backpressure: only the completing chunk stalls.
        out_ready = 1'b0;
        push_frame(4'h1, 4'h2, 4'h3, 4'h4);
        send(4'h1); send(4'h2); send(4'h3); send(4'h4);
        push_frame(4'h5, 4'h6, 4'h7, 4'h8);
        send(4'h5); send(4'h6); send(4'h7);
        #1;
        chk("bp_cnt3", {30'h0, cnt0}, 32'h3);
        in_valid = 1'b1; in_data = 4'h8;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("bp_stall_ready", {31'h0, rdy0}, 32'h0);
            chk("bp_hold_data", {16'h0, od0}, 32'h1234);
            chk("bp_hold_valid", {31'h0, ov0}, 32'h1);
            @(negedge clk);
        end
        out_ready = 1'b1;
        #1;
        chk("bp_release_ready", {31'h0, rdy0}, 32'h1);
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        chk("bp_no_bubble", {31'h0, ov0}, 32'h1);
        chk("bp_new_msb", {16'h0, od0}, 32'h5678);
        chk("bp_new_lsb", {16'h0, od1}, 32'h8765);
        @(negedge clk); #1;
        chk("bp_drained", {31'h0, ov0}, 32'h0);
        @(negedge clk);

        // Abort drops the partial frame and a simultaneous chunk.
        send(4'hF); send(4'hE);
        in_valid = 1'b1; in_data = 4'h9; frame_clear = 1'b1;
        #1;
        chk("abort_ready", {31'h0, rdy0}, 32'h0);
        @(negedge clk);
        frame_clear = 1'b0; in_valid = 1'b0;
        #1;
        chk("abort_cnt", {30'h0, cnt0}, 32'h0);
        chk("abort_no_frame", {31'h0, ov0}, 32'h0);
        @(negedge clk);
        push_frame(4'h1, 4'h2, 4'h3, 4'h4);
        send(4'h1); send(4'h2); send(4'h3); send(4'h4);
        @(negedge clk);

        // ce low freezes the input side; the output side still drains.
        out_ready = 1'b0;
        push_frame(4'hA, 4'h5, 4'hC, 4'h3);
        send(4'hA); send(4'h5); send(4'hC); send(4'h3);
        push_frame(4'h1, 4'h2, 4'h3, 4'h4);
        send(4'h1); send(4'h2);
        ce = 1'b0; in_valid = 1'b1; in_data = 4'h3;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("ce_ready", {31'h0, rdy0}, 32'h0);
            chk("ce_cnt", {30'h0, cnt0}, 32'h2);
            if (i == 1) out_ready = 1'b1;
            if (i == 3) chk("ce_drained", {31'h0, ov0}, 32'h0);
            @(negedge clk);
        end
        ce = 1'b1;
        send(4'h3); send(4'h4);
        repeat (3) @(negedge clk);

        chk("msb_queue_empty", q0.size(), 32'h0);
        chk("lsb_queue_empty", q1.size(), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
